// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port sequencer for a single-port combinational-read, level-write data memory
module dmem_arbiter #(
  parameter int BUS_WIDTH      = 8,
  parameter int FIXED_PRIORITY = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0,
  input  logic                 req1,
  input  logic                 we0,
  input  logic                 we1,
  input  logic [BUS_WIDTH-1:0] addr0,
  input  logic [BUS_WIDTH-1:0] addr1,
  input  logic [BUS_WIDTH-1:0] wdata0,
  input  logic [BUS_WIDTH-1:0] wdata1,
  output logic                 ack0,
  output logic                 ack1,
  output logic [BUS_WIDTH-1:0] rdata0,
  output logic [BUS_WIDTH-1:0] rdata1,
  output logic                 busy,
  output logic [BUS_WIDTH-1:0] memAddress,
  output logic [BUS_WIDTH-1:0] memWData,
  output logic                 memReadWrite,
  input  logic [BUS_WIDTH-1:0] memRData
);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;
  state_t state;
  logic owner, last_grant, we_l;
  logic m0, m1, hold, grant, win;
  // Arbitration: the finishing owner is masked in DONE, except that fixed
  // priority keeps port 0 in charge while it still requests (it re-wins from IDLE)
  always_comb begin
    m0    = req0 & ~(state == DONE && !owner);
    m1    = req1 & ~(state == DONE && owner);
    hold  = (FIXED_PRIORITY != 0) && state == DONE && !owner && req0;
    grant = (state == IDLE || state == DONE) && (m0 | m1) && !hold;
    win   = (m0 & m1) ? ((FIXED_PRIORITY != 0) ? 1'b0 : ~last_grant) : m1;
  end
  // Sequencer with registered memory controls so the write level never overlaps an address change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      we_l         <= 1'b0;
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      rdata0       <= '0;
      rdata1       <= '0;
      busy         <= 1'b0;
      memAddress   <= '0;
      memWData     <= '0;
      memReadWrite <= 1'b0;
    end else begin
      ack0         <= 1'b0;
      ack1         <= 1'b0;
      memReadWrite <= 1'b0;
      case (state)
        SETUP: begin
          memReadWrite <= we_l;
          state        <= STROBE;
        end
        STROBE: begin
          ack0  <= ~owner;
          ack1  <= owner;
          state <= DONE;
          if (!we_l && !owner) rdata0 <= memRData;
          if (!we_l && owner) rdata1 <= memRData;
        end
        default: begin
          busy  <= grant;
          state <= grant ? SETUP : IDLE;
          if (grant) begin
            owner      <= win;
            last_grant <= win;
            we_l       <= win ? we1 : we0;
            memAddress <= win ? addr1 : addr0;
            memWData   <= win ? wdata1 : wdata0;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of sequencing, arbitration and reset behaviour
module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic req0, req1, we0, we1;
  logic [7:0] addr0, addr1, wdata0, wdata1;
  logic ack0, ack1, busy, mem_rw;
  logic [7:0] rdata0, rdata1, mem_addr, mem_wd, mem_rd;
  logic f_ack0, f_ack1, f_busy, f_rw;
  logic [7:0] f_rdata0, f_rdata1, f_addr, f_wd;
  logic [7:0] mem [256];
  int n_cmp = 0, n_bad = 0, both_ack = 0;
  dmem_arbiter #(.BUS_WIDTH(8), .FIXED_PRIORITY(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1), .busy(busy),
    .memAddress(mem_addr), .memWData(mem_wd), .memReadWrite(mem_rw), .memRData(mem_rd));
  dmem_arbiter #(.BUS_WIDTH(8), .FIXED_PRIORITY(1)) u_fix (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(f_ack0), .ack1(f_ack1), .rdata0(f_rdata0), .rdata1(f_rdata1), .busy(f_busy),
    .memAddress(f_addr), .memWData(f_wd), .memReadWrite(f_rw), .memRData(8'h00));
  always @(posedge clk) if (mem_rw) mem[mem_addr] <= mem_wd;
  assign mem_rd = mem[mem_addr];
  always @(negedge clk) if (ack0 && ack1) both_ack <= both_ack + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic xact(input bit p, input bit w, input logic [7:0] a, input logic [7:0] d,
                      output int at, output int rwn, output logic [7:0] ra,
                      output logic [7:0] rwd, output logic [7:0] rd);
    @(negedge clk);
    if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    else begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    at = -1; rwn = 0; ra = '0; rwd = '0; rd = '0;
    for (int c = 1; c <= 8 && at < 0; c++) begin
      @(negedge clk);
      if (mem_rw) begin rwn++; ra = mem_addr; rwd = mem_wd; end
      if (p ? ack1 : ack0) begin at = c; rd = p ? rdata1 : rdata0; end
    end
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  initial begin
    int at, rwn, n, a0, a1, cnt0, cnt1, last0;
    int cyc [4];
    logic prt [4];
    logic [7:0] ra, rwd, rd, r1, dat [4];
    logic [7:0] pa [6];
    logic [7:0] pd [6];
    pa = '{8'h01, 8'h05, 8'h06, 8'h07, 8'h20, 8'h99};
    pd = '{8'h4E, 8'h11, 8'h22, 8'h33, 8'h6B, 8'hC4};
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_rw", mem_rw, 0);
    rst_n = 1'b1;
    // reset in the middle of a write strobe
    @(negedge clk);
    req0 = 1; we0 = 1; addr0 = 8'h10; wdata0 = 8'h55;
    @(negedge clk);
    check("setup_addr", mem_addr, 8'h10);
    check("setup_rw", mem_rw, 0);
    check("setup_busy", busy, 1);
    @(negedge clk);
    check("strobe_rw", mem_rw, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rw", mem_rw, 0);
    check("async_busy", busy, 0);
    check("async_addr", mem_addr, 0);
    check("async_wdata", mem_wd, 0);
    check("async_ack", {ack0, ack1}, 0);
    req0 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_busy", busy, 0);
    check("post_ack", ack0, 0);
    // single write then read on port 0
    xact(0, 1, 8'h3C, 8'hA5, at, rwn, ra, rwd, rd);
    check("wr_ack_cyc", at, 3);
    check("wr_rw_cnt", rwn, 1);
    check("wr_rw_addr", ra, 8'h3C);
    check("wr_rw_data", rwd, 8'hA5);
    xact(0, 0, 8'h3C, 8'h00, at, rwn, ra, rwd, rd);
    check("rd_ack_cyc", at, 3);
    check("rd_rw_cnt", rwn, 0);
    check("rd_data", rd, 8'hA5);
    // preload via port 1 writes
    for (int i = 0; i < 6; i++) begin
      xact(1, 1, pa[i], pd[i], at, rwn, ra, rwd, rd);
      check("pre_ack", at, 3);
    end
    // contention from reset: port 0 first
    do_reset();
    req0 = 1; we0 = 0; addr0 = 8'h01;
    req1 = 1; we1 = 1; addr1 = 8'h02; wdata1 = 8'h77;
    a0 = -1; a1 = -1; rd = 0; r1 = 8'hFF;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (ack0 && a0 < 0) begin a0 = c; rd = rdata0; req0 = 0; end
      if (ack1 && a1 < 0) begin a1 = c; r1 = rdata1; req1 = 0; end
    end
    check("cont_ack0", a0, 3);
    check("cont_ack1", a1, 6);
    check("cont_rdata0", rd, 8'h4E);
    check("cont_rdata1_keep", r1, 8'h00);
    check("cont_mem", mem[8'h02], 8'h77);
    // both held: grants alternate
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 8'h05;
    req1 = 1; we1 = 0; addr1 = 8'h06;
    n = 0;
    for (int c = 1; c <= 20 && n < 4; c++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        prt[n] = ack1; cyc[n] = c; n++;
        if (n == 4) begin req0 = 0; req1 = 0; end
      end
    end
    check("rr_count", n, 4);
    for (int i = 0; i < 4; i++) begin
      check("rr_port", prt[i], i % 2);
      check("rr_cyc", cyc[i], 3 * (i + 1));
    end
    // back-to-back reads on port 0
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 8'h05;
    n = 0;
    for (int c = 1; c <= 20 && n < 3; c++) begin
      @(negedge clk);
      if (ack0) begin
        cyc[n] = c; dat[n] = rdata0; n++;
        addr0 = 8'h05 + 8'(n);
        if (n == 3) req0 = 0;
      end
    end
    check("b2b_count", n, 3);
    check("b2b_cyc0", cyc[0], 3);
    check("b2b_cyc1", cyc[1], 7);
    check("b2b_cyc2", cyc[2], 11);
    check("b2b_dat0", dat[0], 8'h11);
    check("b2b_dat1", dat[1], 8'h22);
    check("b2b_dat2", dat[2], 8'h33);
    // address change after grant is ignored
    @(negedge clk);
    req0 = 1; we0 = 0; addr0 = 8'h20;
    at = -1; rd = 0;
    for (int c = 1; c <= 8 && at < 0; c++) begin
      @(negedge clk);
      if (c == 1) addr0 = 8'h99;
      if (ack0) begin at = c; rd = rdata0; end
    end
    req0 = 0;
    check("stab_ack", at, 3);
    check("stab_data", rd, 8'h6B);
    // port 1 write leaves rdata1 unchanged
    xact(1, 0, 8'h02, 8'h00, at, rwn, ra, rwd, rd);
    check("p1_rd", rd, 8'h77);
    xact(1, 1, 8'h40, 8'h12, at, rwn, ra, rwd, rd);
    check("p1_wr_ack", at, 3);
    check("p1_rdata_keep", rdata1, 8'h77);
    check("p1_mem", mem[8'h40], 8'h12);
    // fixed priority instance
    do_reset();
    req0 = 1; we0 = 0; addr0 = 8'h05;
    req1 = 1; we1 = 0; addr1 = 8'h06;
    cnt0 = 0; cnt1 = 0; last0 = -1;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (f_ack0) begin cnt0++; last0 = c; end
      if (f_ack1) cnt1++;
      if (c == 11) req0 = 0;
    end
    check("fix_ack0_cnt", cnt0, 3);
    check("fix_ack0_last", last0, 11);
    check("fix_ack1_cnt", cnt1, 0);
    at = -1;
    for (int c = 12; c <= 20 && at < 0; c++) begin
      @(negedge clk);
      if (f_ack1) at = c;
    end
    req1 = 0;
    check("fix_ack1_cyc", at, 14);
    check("no_dual_ack", both_ack, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
